// File: rtl/yuv_upsample_csc_engine_if.sv
// SRAM port bundle for the YUV->RGB engine.
// The engine drives address/data/we_n; the memory side returns read data.
interface yuv_upsample_csc_engine_if;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    input  SRAM_read_data,
    output SRAM_address,
    output SRAM_write_data,
    output SRAM_we_n
  );

  modport slave (
    output SRAM_read_data,
    input  SRAM_address,
    input  SRAM_write_data,
    input  SRAM_we_n
  );
endinterface

// File: rtl/yuv_upsample_csc_engine.sv
// Frame engine: reads YUV 4:2:2 planes, upsamples U/V horizontally,
// converts to RGB and writes packed RGB words back to SRAM.
module yuv_upsample_csc_engine #(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int Y_BASE   = 0,
  parameter int U_BASE   = 38400,
  parameter int V_BASE   = 57600,
  parameter int RGB_BASE = 146944,
  parameter int UPS_MODE = 0
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic Start,
  yuv_upsample_csc_engine_if.master sram,
  output logic Busy,
  output logic Done
);

  localparam int HW  = WIDTH / 2;
  localparam int UVW = (HW + 1) / 2;
  localparam logic [17:0] HW_L   = 18'(HW);
  localparam logic [17:0] UVW_L  = 18'(UVW);
  localparam logic [17:0] LAST_K = 18'(HW - 1);
  localparam logic [17:0] LAST_R = 18'(HEIGHT - 1);
  localparam logic [17:0] YB_L   = 18'(Y_BASE);
  localparam logic [17:0] UB_L   = 18'(U_BASE);
  localparam logic [17:0] VB_L   = 18'(V_BASE);
  localparam logic [17:0] RB_L   = 18'(RGB_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_IN,
    S_CC,
    S_LEAD_OUT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ph_q, ph_d;
  logic [17:0] k_q, k_d;
  logic [17:0] row_q, row_d;
  logic [17:0] yrow_q, yrow_d;
  logic [17:0] uvrow_q, uvrow_d;
  logic [17:0] wa_q, wa_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_n_q, we_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0][7:0] ut_q, ut_d;
  logic [5:0][7:0] vt_q, vt_d;
  logic [15:0] ypr_q, ypr_d;
  logic [15:0] ynx_q, ynx_d;
  logic [7:0]  un_q, un_d;
  logic [7:0]  uo_q, uo_d;
  logic [7:0]  vo_q, vo_d;
  logic [23:0] p0_q, p0_d;
  logic [23:0] p1_q, p1_d;
  logic [17:0] jn;
  logic [17:0] yi;
  logic [15:0] rd;

  function automatic logic [7:0] clip8(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return x[7:0];
  endfunction

  function automatic logic [7:0] fir6(input logic [5:0][7:0] t);
    int acc;
    acc = 21 * (int'(t[0]) + int'(t[5]))
        - 52 * (int'(t[1]) + int'(t[4]))
        + 159 * (int'(t[2]) + int'(t[3]))
        + 128;
    return clip8(acc >>> 8);
  endfunction

  function automatic logic [23:0] csc(
    input logic [7:0] y,
    input logic [7:0] u,
    input logic [7:0] v
  );
    int ya, uu, vv, r, g, b;
    ya = 76284 * (int'(y) - 16);
    uu = int'(u) - 128;
    vv = int'(v) - 128;
    r  = (ya + 104595 * vv) >>> 16;
    g  = (ya - 25624 * uu - 53281 * vv) >>> 16;
    b  = (ya + 132251 * uu) >>> 16;
    return {clip8(r), clip8(g), clip8(b)};
  endfunction

  function automatic logic [7:0] pick(
    input logic [15:0] w,
    input logic        odd
  );
    return odd ? w[7:0] : w[15:8];
  endfunction

  assign rd = sram.SRAM_read_data;
  // next chroma sample to shift in, clamped at the row end
  assign jn = (k_q + 18'd4 > LAST_K) ? LAST_K : k_q + 18'd4;
  assign yi = (k_q == LAST_K) ? k_q : k_q + 18'd1;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    k_d     = k_q;
    row_d   = row_q;
    yrow_d  = yrow_q;
    uvrow_d = uvrow_q;
    wa_d    = wa_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ut_d    = ut_q;
    vt_d    = vt_q;
    ypr_d   = ypr_q;
    ynx_d   = ynx_q;
    un_d    = un_q;
    uo_d    = uo_q;
    vo_d    = vo_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_LEAD_IN;
          ph_d    = 3'd0;
          k_d     = '0;
          row_d   = '0;
          yrow_d  = YB_L;
          uvrow_d = '0;
          wa_d    = RB_L;
          busy_d  = 1'b1;
        end
      end
      S_LEAD_IN: begin
        ph_d = ph_q + 3'd1;
        // bus lags decision by 1 clock, read data by 3
        case (ph_q)
          3'd0: addr_d = UB_L + uvrow_q;
          3'd1: addr_d = UB_L + uvrow_q + 18'd1;
          3'd2: addr_d = VB_L + uvrow_q;
          3'd3: begin
            addr_d = VB_L + uvrow_q + 18'd1;
            ut_d[0] = rd[15:8];
            ut_d[1] = rd[15:8];
            ut_d[2] = rd[15:8];
            ut_d[3] = rd[7:0];
          end
          3'd4: begin
            addr_d = yrow_q;
            ut_d[4] = rd[15:8];
            ut_d[5] = rd[7:0];
          end
          3'd5: begin
            vt_d[0] = rd[15:8];
            vt_d[1] = rd[15:8];
            vt_d[2] = rd[15:8];
            vt_d[3] = rd[7:0];
          end
          3'd6: begin
            vt_d[4] = rd[15:8];
            vt_d[5] = rd[7:0];
          end
          default: begin
            ypr_d   = rd;
            state_d = S_CC;
            ph_d    = 3'd0;
          end
        endcase
      end
      S_CC: begin
        ph_d = ph_q + 3'd1;
        case (ph_q)
          3'd0: begin
            addr_d = yrow_q + yi;
            uo_d = (UPS_MODE == 1) ? ut_q[2] : fir6(ut_q);
            vo_d = (UPS_MODE == 1) ? vt_q[2] : fir6(vt_q);
          end
          3'd1: begin
            addr_d = UB_L + uvrow_q + (jn >> 1);
            p0_d = csc(ypr_q[15:8], ut_q[2], vt_q[2]);
            p1_d = csc(ypr_q[7:0], uo_q, vo_q);
          end
          3'd2: addr_d = VB_L + uvrow_q + (jn >> 1);
          3'd3: begin
            ynx_d   = rd;
            addr_d  = wa_q;
            wdata_d = {p0_q[23:16], p0_q[15:8]};
            we_n_d  = 1'b0;
            wa_d    = wa_q + 18'd1;
          end
          3'd4: begin
            un_d    = pick(rd, jn[0]);
            addr_d  = wa_q;
            wdata_d = {p0_q[7:0], p1_q[23:16]};
            we_n_d  = 1'b0;
            wa_d    = wa_q + 18'd1;
          end
          default: begin
            addr_d  = wa_q;
            wdata_d = {p1_q[15:8], p1_q[7:0]};
            we_n_d  = 1'b0;
            wa_d    = wa_q + 18'd1;
            ut_d    = {un_q, ut_q[5:1]};
            vt_d    = {pick(rd, jn[0]), vt_q[5:1]};
            ypr_d   = ynx_q;
            ph_d    = 3'd0;
            if (k_q == LAST_K) begin
              state_d = S_LEAD_OUT;
              k_d     = '0;
            end else begin
              k_d = k_q + 18'd1;
            end
          end
        endcase
      end
      S_LEAD_OUT: begin
        if (row_q == LAST_R) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_LEAD_IN;
          ph_d    = 3'd0;
          row_d   = row_q + 18'd1;
          yrow_d  = yrow_q + HW_L;
          uvrow_d = uvrow_q + UVW_L;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      k_q     <= '0;
      row_q   <= '0;
      yrow_q  <= '0;
      uvrow_q <= '0;
      wa_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ut_q    <= '0;
      vt_q    <= '0;
      ypr_q   <= '0;
      ynx_q   <= '0;
      un_q    <= '0;
      uo_q    <= '0;
      vo_q    <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      k_q     <= k_d;
      row_q   <= row_d;
      yrow_q  <= yrow_d;
      uvrow_q <= uvrow_d;
      wa_q    <= wa_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ut_q    <= ut_d;
      vt_q    <= vt_d;
      ypr_q   <= ypr_d;
      ynx_q   <= ynx_d;
      un_q    <= un_d;
      uo_q    <= uo_d;
      vo_q    <= vo_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
    end
  end

  assign sram.SRAM_address    = addr_q;
  assign sram.SRAM_write_data = wdata_q;
  assign sram.SRAM_we_n       = we_n_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_yuv_upsample_csc_engine.sv
// Directed bench: FIR and replicate instances run the same frames
// side by side against hand-computed RGB words.
module tb_yuv_upsample_csc_engine;
  localparam int W  = 12;
  localparam int H  = 4;
  localparam int YB = 0;
  localparam int UB = 64;
  localparam int VB = 128;
  localparam int RB = 256;
  localparam int NW = 3 * W / 2 * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy0, done0, busy1, done1;

  yuv_upsample_csc_engine_if if0();
  yuv_upsample_csc_engine_if if1();

  always #5 clk = ~clk;

  yuv_upsample_csc_engine #(
    .WIDTH(W), .HEIGHT(H), .Y_BASE(YB), .U_BASE(UB),
    .V_BASE(VB), .RGB_BASE(RB), .UPS_MODE(0)
  ) u_fir (
    .Clock(clk), .Resetn(rst_n), .Start(start),
    .sram(if0.master), .Busy(busy0), .Done(done0)
  );

  yuv_upsample_csc_engine #(
    .WIDTH(W), .HEIGHT(H), .Y_BASE(YB), .U_BASE(UB),
    .V_BASE(VB), .RGB_BASE(RB), .UPS_MODE(1)
  ) u_rep (
    .Clock(clk), .Resetn(rst_n), .Start(start),
    .sram(if1.master), .Busy(busy1), .Done(done1)
  );

  logic [15:0] mem0 [512];
  logic [15:0] mem1 [512];
  logic [15:0] pl0, pl1;
  int hits0 [512];
  int wcnt0 = 0;
  int wcnt1 = 0;
  int dcnt0 = 0;
  int hicnt = 0;
  logic        bd_we = 1'b0;
  logic [8:0]  bd_a = '0;
  logic [15:0] bd_d = '0;

  always @(posedge clk) begin
    if (bd_we) begin
      mem0[bd_a] <= bd_d;
      mem1[bd_a] <= bd_d;
    end
    if (!if0.SRAM_we_n) begin
      mem0[if0.SRAM_address[8:0]] <= if0.SRAM_write_data;
      hits0[if0.SRAM_address[8:0]] <= hits0[if0.SRAM_address[8:0]] + 1;
      wcnt0 <= wcnt0 + 1;
      if (if0.SRAM_address[17:9] != 0) hicnt <= hicnt + 1;
    end
    if (!if1.SRAM_we_n) begin
      mem1[if1.SRAM_address[8:0]] <= if1.SRAM_write_data;
      wcnt1 <= wcnt1 + 1;
    end
    pl0 <= mem0[if0.SRAM_address[8:0]];
    pl1 <= mem1[if1.SRAM_address[8:0]];
    if0.SRAM_read_data <= pl0;
    if1.SRAM_read_data <= pl1;
    if (done0) dcnt0 <= dcnt0 + 1;
  end

  int total = 0;
  int bad = 0;
  logic [15:0] e0 [NW];
  logic [15:0] e1 [NW];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bd(input int a, input logic [15:0] d);
    bd_we = 1'b1;
    bd_a  = 9'(a);
    bd_d  = d;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic load(input bit mixed);
    logic [15:0] yw, uw, vw;
    for (int r = 0; r < H; r++) begin
      yw = 16'h1010;
      if (mixed && r == 2) yw = 16'hEBEB;
      if (mixed && r == 3) yw = 16'hFFFF;
      for (int j = 0; j < W / 2; j++) bd(YB + r * (W / 2) + j, yw);
      for (int j = 0; j < 3; j++) begin
        uw = 16'h8080;
        vw = 16'h8080;
        if (mixed && r == 0) uw = (j == 0) ? 16'hC800 : 16'h0000;
        if (mixed && r == 1 && j == 2) vw = 16'h80E4;
        bd(UB + r * 3 + j, uw);
        bd(VB + r * 3 + j, vw);
      end
    end
    for (int i = 0; i <= NW; i++) bd(RB + i, 16'hDEAD);
  endtask

  task automatic set_exp(input bit mixed);
    for (int i = 0; i < NW; i++) begin
      e0[i] = 16'h0000;
      e1[i] = 16'h0000;
    end
    if (mixed) begin
      for (int k = 0; k < W / 2; k++) begin
        e0[3 * k] = 16'h0032;
        e0[3 * k + 2] = 16'h3200;
        e1[3 * k] = 16'h0032;
        e1[3 * k + 2] = 16'h3200;
      end
      e0[0] = 16'h0000; e0[1] = 16'h9100; e0[2] = 16'h0A00;
      e0[8] = 16'h2B00;
      e1[0] = 16'h0000; e1[1] = 16'h9100; e1[2] = 16'h0091;
      e0[25] = 16'h000C; e0[29] = 16'h0900; e0[31] = 16'h004F;
      e0[33] = 16'h9F00; e0[34] = 16'h00B2;
      e1[33] = 16'h9F00; e1[34] = 16'h009F;
      for (int i = 36; i < 54; i++) begin
        e0[i] = 16'hFEFE;
        e1[i] = 16'hFEFE;
      end
      for (int i = 54; i < NW; i++) begin
        e0[i] = 16'hFFFF;
        e1[i] = 16'hFFFF;
      end
    end
  endtask

  task automatic check_frame();
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("fir_w%0d", i), 32'(mem0[RB + i]), 32'(e0[i]));
      chk($sformatf("rep_w%0d", i), 32'(mem1[RB + i]), 32'(e1[i]));
    end
    chk("guard", 32'(mem0[RB + NW]), 32'hDEAD);
  endtask

  task automatic run_frame(input bit dbl);
    int wb, w1b, db, n, errs;
    int hb [512];
    wb  = wcnt0;
    w1b = wcnt1;
    db  = dcnt0;
    hb  = hits0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_start", 32'(busy0), 32'd1);
    if (dbl) begin
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    n = 0;
    while (!done0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done0), 32'd1);
    chk("done_rep", 32'(done1), 32'd1);
    @(negedge clk);
    chk("busy_after", 32'(busy0), 32'd0);
    chk("done_pulse", 32'(done0), 32'd0);
    repeat (5) @(negedge clk);
    chk("done_cnt", 32'(dcnt0 - db), 32'd1);
    chk("wr_cnt", 32'(wcnt0 - wb), 32'(NW));
    chk("wr_cnt_rep", 32'(wcnt1 - w1b), 32'(NW));
    errs = 0;
    for (int i = 0; i < NW; i++)
      if (hits0[RB + i] - hb[RB + i] != 1) errs++;
    chk("once_each", 32'(errs), 32'd0);
    chk("hi_addr", 32'(hicnt), 32'd0);
  endtask

  initial begin
    int wb, db, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we_n", 32'(if0.SRAM_we_n), 32'd1);
    chk("rst_addr", 32'(if0.SRAM_address), 32'd0);
    chk("rst_wdata", 32'(if0.SRAM_write_data), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    rst_n = 1'b1;

    load(1'b0);
    set_exp(1'b0);
    run_frame(1'b1);
    check_frame();

    load(1'b1);
    set_exp(1'b1);
    wb = wcnt0;
    db = dcnt0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while ((wcnt0 - wb) < 40 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach", 32'((wcnt0 - wb) >= 40), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_we_n", 32'(if0.SRAM_we_n), 32'd1);
    chk("mid_addr", 32'(if0.SRAM_address), 32'd0);
    chk("mid_wdata", 32'(if0.SRAM_write_data), 32'd0);
    chk("mid_busy", 32'(busy0), 32'd0);
    chk("mid_done", 32'(done0), 32'd0);
    chk("mid_busy_rep", 32'(busy1), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_no_done", 32'(dcnt0 - db), 32'd0);
    rst_n = 1'b1;

    load(1'b1);
    run_frame(1'b0);
    check_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
